// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and default width for the EX-stage ALU
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam int ALU_AND   = 0;
    localparam int ALU_OR    = 1;
    localparam int ALU_ADD   = 2;
    localparam int ALU_MFHI  = 3;
    localparam int ALU_MFLO  = 4;
    localparam int ALU_MULT  = 5;
    localparam int ALU_SUB   = 6;
    localparam int ALU_SLT   = 7;
    localparam int ALU_DIV   = 8;
    localparam int ALU_MULTU = 9;
    localparam int ALU_DIVU  = 10;
    localparam int ALU_SLTU  = 11;
    localparam int ALU_NOR   = 12;
    localparam int ALU_MTHI  = 13;
    localparam int ALU_MTLO  = 14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - start/busy/done request bus between control unit and ALU
interface alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             start;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, in1, in2,
        input  result, busy, done, div_zero
    );

    modport slave (
        input  start, op, in1, in2,
        output result, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiply / restoring divide datapath
module muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   opd;
    logic [CW-1:0]      cnt;
    logic               div_mode;
    logic               neg_lo;
    logic               neg_hi;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign sum   = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
    // A borrow out of the top bit means the partial remainder stays as is.
    assign trial = {acc, mq[WIDTH-1]} - {1'b0, opd};

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mq       <= '0;
            opd      <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            mq       <= a_mag;
            opd      <= b_mag;
            cnt      <= '0;
            div_mode <= is_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= is_div ? a_neg : (a_neg ^ b_neg);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_mode) begin
                if (!trial[WIDTH]) begin
                    acc <= trial[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= {acc[WIDTH-2:0], mq[WIDTH-1]};
                    mq  <= {mq[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= sum[WIDTH:1];
                mq  <= {sum[0], mq[WIDTH-1:1]};
            end
        end
    end

    // Quotient and remainder carry separate signs; the product is negated as one.
    assign prod     = {acc, mq};
    assign prod_fix = neg_lo ? -prod : prod;

    assign hi = div_mode ? (neg_hi ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo = div_mode ? (neg_lo ? -mq  : mq)  : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - clocked EX-stage ALU with iterative mul/div and HI/LO
module alu_muldiv import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_muldiv_if.slave bus
);
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             is_signed;
    logic             div_by_zero;
    logic             load;
    logic             step;
    logic             last;

    assign accept      = bus.start && (state_q == S_IDLE);
    assign is_mul      = (bus.op == OPW'(ALU_MULT)) || (bus.op == OPW'(ALU_MULTU));
    assign is_div      = (bus.op == OPW'(ALU_DIV))  || (bus.op == OPW'(ALU_DIVU));
    assign is_signed   = (bus.op == OPW'(ALU_MULT)) || (bus.op == OPW'(ALU_DIV));
    assign div_by_zero = is_div && (bus.in2 == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (bus.in1),
        .b         (bus.in2),
        .last      (last),
        .hi        (fix_hi),
        .lo        (fix_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    load    = 1'b1;
                    state_d = S_MUL;
                end else if (accept && is_div && !div_by_zero) begin
                    load    = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (last) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        simple_res = '0;
        case (bus.op)
            OPW'(ALU_AND):  simple_res = bus.in1 & bus.in2;
            OPW'(ALU_OR):   simple_res = bus.in1 | bus.in2;
            OPW'(ALU_ADD):  simple_res = bus.in1 + bus.in2;
            OPW'(ALU_SUB):  simple_res = bus.in1 - bus.in2;
            OPW'(ALU_SLT):  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            OPW'(ALU_SLTU): simple_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            OPW'(ALU_NOR):  simple_res = ~(bus.in1 | bus.in2);
            OPW'(ALU_MFHI): simple_res = hi_q;
            OPW'(ALU_MFLO): simple_res = lo_q;
            OPW'(ALU_MTHI): simple_res = bus.in1;
            OPW'(ALU_MTLO): simple_res = bus.in1;
            default:        simple_res = '0;
        endcase
    end

    // Simple ops and divide-by-zero complete at the accept edge; mul/div at FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d != S_IDLE);
            if (state_q == S_FIX) begin
                hi_q     <= fix_hi;
                lo_q     <= fix_lo;
                result_q <= fix_lo;
                done_q   <= 1'b1;
                dz_q     <= 1'b0;
            end else if (accept && !load) begin
                done_q <= 1'b1;
                if (div_by_zero) begin
                    dz_q     <= 1'b1;
                    result_q <= lo_q;
                end else begin
                    dz_q     <= 1'b0;
                    result_q <= simple_res;
                    if (bus.op == OPW'(ALU_MTHI)) hi_q <= bus.in1;
                    if (bus.op == OPW'(ALU_MTLO)) lo_q <= bus.in1;
                end
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed vector bench for alu_muldiv
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_muldiv #(.WIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    // Issue one op after a clock edge and wait (bounded) for done.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dz, output int cyc, output int bcnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) bcnt++;
        end
        res = bus.result;
        dz  = bus.div_zero;
    endtask

    initial begin
        logic [31:0] res;
        logic        dz;
        int          cyc;
        int          bcnt;
        int          dcnt;
        logic [31:0] bb_op[4];
        logic [31:0] bb_a[4];
        logic [31:0] bb_b[4];
        logic [31:0] bb_exp[4];

        tbl.push_back('{4'(ALU_AND),   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 0});
        tbl.push_back('{4'(ALU_OR),    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 0});
        tbl.push_back('{4'(ALU_ADD),   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0});
        tbl.push_back('{4'(ALU_SUB),   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 0});
        tbl.push_back('{4'(ALU_SLT),   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0});
        tbl.push_back('{4'(ALU_SLTU),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0});
        tbl.push_back('{4'(ALU_NOR),   32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 1'b0, 0});
        tbl.push_back('{4'(15),        32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 0});
        tbl.push_back('{4'(ALU_MTHI),  32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 1'b0, 0});
        tbl.push_back('{4'(ALU_MTLO),  32'h0000_0022, 32'h0000_0000, 32'h0000_0022, 1'b0, 0});
        tbl.push_back('{4'(ALU_DIVU),  32'h0000_0005, 32'h0000_0000, 32'h0000_0022, 1'b1, 0});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'h0000_0011, 1'b0, 0});
        tbl.push_back('{4'(ALU_MFLO),  32'h0000_0000, 32'h0000_0000, 32'h0000_0022, 1'b0, 0});
        tbl.push_back('{4'(ALU_MULT),  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0});
        tbl.push_back('{4'(ALU_MULTU), 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 0});
        tbl.push_back('{4'(ALU_DIV),   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0});
        tbl.push_back('{4'(ALU_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0});
        tbl.push_back('{4'(ALU_DIVU),  32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 1'b0, 0});
        tbl.push_back('{4'(ALU_DIV),   32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33});
        tbl.push_back('{4'(ALU_MFHI),  32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 0});

        bus.start = 1'b0;
        bus.op    = '0;
        bus.in1   = '0;
        bus.in2   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        chk("reset_div_zero", {31'b0, bus.div_zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, dz, cyc, bcnt);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_div_zero", i), {31'b0, dz}, {31'b0, tbl[i].dz});
            chk($sformatf("vec%0d_latency", i), cyc, tbl[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].lat);
        end

        // Back-to-back simple ops, one accept per edge.
        bb_op  = '{32'(ALU_ADD), 32'(ALU_SLT), 32'(ALU_SLTU), 32'(ALU_NOR)};
        bb_a   = '{32'hFFFF_FFFF, 32'h5, 32'h1, 32'h0};
        bb_b   = '{32'h1, 32'h3, 32'hFFFF_FFFF, 32'h0};
        bb_exp = '{32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF};
        for (int k = 0; k < 4; k++) begin
            bus.start = 1'b1;
            bus.op    = bb_op[k][3:0];
            bus.in1   = bb_a[k];
            bus.in2   = bb_b[k];
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_done", k), {31'b0, bus.done}, 32'h1);
            chk($sformatf("b2b%0d_result", k), bus.result, bb_exp[k]);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_done_drops", {31'b0, bus.done}, 32'h0);

        // Start while busy: the ADD raised mid-divide must be dropped.
        bus.start = 1'b1;
        bus.op    = 4'(ALU_DIVU);
        bus.in1   = 32'd100;
        bus.in2   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dcnt = 0;
        res  = 32'h0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dcnt++;
                res = bus.result;
            end
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = 4'(ALU_ADD);
                bus.in1   = 32'd1;
                bus.in2   = 32'd2;
            end else if (c == 6) begin
                bus.start = 1'b0;
            end
        end
        chk("busy_start_done_count", dcnt, 1);
        chk("busy_start_result", res, 32'd14);

        // Reset mid-MULT discards the op and clears HI/LO.
        bus.start = 1'b1;
        bus.op    = 4'(ALU_MULT);
        bus.in1   = 32'd7;
        bus.in2   = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midmul_busy_before_reset", {31'b0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midmul_reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("midmul_reset_done", {31'b0, bus.done}, 32'h0);
        chk("midmul_reset_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midmul_idle_after_release", {31'b0, bus.done}, 32'h0);
        do_op(4'(ALU_MFLO), 32'h0, 32'h0, res, dz, cyc, bcnt);
        chk("midmul_mflo", res, 32'h0);
        do_op(4'(ALU_MFHI), 32'h0, 32'h0, res, dz, cyc, bcnt);
        chk("midmul_mfhi", res, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU.
- Adds signed and unsigned multiply and divide, computed iteratively in a small FSM, with architectural HI/LO registers.
- Uses a start/busy/done handshake toward the control unit; the pipeline stalls while busy=1.
- Sits in EX, between the register-file read muxes and the data-memory address / writeback mux.

Parameters:
- WIDTH, 32, operand/result/HI/LO width (≥4, even).
- OPW, 4, width of op code from ALU control.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; op accepted on edge where start=1 and busy=0
- op  in  OPW  operation code (sampled at accept)
- in1  in  WIDTH  operand A (rs); sampled at accept
- in2  in  WIDTH  operand B (rt/imm); sampled at accept
- result  out  WIDTH  registered result; holds until next completion
- busy  out  1  high while an op is in flight
- done  out  1  one-cycle pulse: result/HI/LO updated
- div_zero  out  1  valid with done; divide with in2==0

Behaviour:
- Op codes: 0 AND, 1 OR, 2 ADD, 3 MFHI, 4 MFLO, 5 MULT (signed), 6 SUB, 7 SLT (signed), 8 DIV (signed), 9 MULTU, 10 DIVU, 11 SLTU, 12 NOR, 13 MTHI (HI<=in1), 14 MTLO (LO<=in1), 15 reserved.
- Reserved op: result 0, done pulse, no HI/LO change.
- Reset (async, rst_n=0): result=0, HI=0, LO=0, busy=0, done=0, div_zero=0, FSM=IDLE. Any in-flight op is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE, accept, simple op (not 5/8/9/10): result computed and registered at the accept edge; done=1 the following cycle; busy stays 0; FSM stays IDLE. Back-to-back simple ops may issue every cycle.
  - IDLE, accept, MULT/MULTU: latch |A|, |B| (magnitudes for signed, raw for unsigned) and the sign flag; busy<=1; go to MUL. Shift-add one bit per cycle, WIDTH cycles, then FIX.
  - IDLE, accept, DIV/DIVU with in2!=0: as above; go to DIV. Restoring division one bit per cycle, WIDTH cycles, then FIX.
  - IDLE, accept, DIV/DIVU with in2==0: no iteration. Next edge: done=1, div_zero=1, HI/LO unchanged, result=LO (old value), busy stays 0.
  - FIX (1 cycle): apply sign correction; write HI/LO/result (result=LO); busy<=0; done<=1; return to IDLE.
- Latency for mul/div: accept at edge 0, iterations at edges 1..WIDTH, FIX at edge WIDTH+1. busy is 1 from edge 0 through edge WIDTH+1; done is high for the single cycle after edge WIDTH+1.
- start while busy=1: ignored; the op is not queued. Control must hold the request.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT/SLTU produce 1 or 0, zero-extended; the false case is explicitly 0.
  - Product is 2·WIDTH bits: {HI,LO}.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed divide MIN/−1: LO=MIN (wrap), HI=0.
- MFHI/MFLO issued the cycle after a mul/div done see the updated HI/LO.
- div_zero is cleared on every done that is not a divide-by-zero.
- No combinational path from inputs to outputs.

Decomposition:
- Package alu_pkg: op-code localparams (ALU_AND … ALU_MTLO), FSM state enum, WIDTH default.
- Sub-module muldiv_iter: the iterative MUL/DIV datapath (accumulator, shift register, count, sign fix), controlled by the alu_muldiv FSM.
- Simple ops stay inline in alu_muldiv.

Test Plan:
- Reset mid-MULT: issue MULT 7×9, pull rst_n low at iteration 10 → busy=0, done=0, HI=LO=result=0 immediately. After release, MFLO → 0.
- Signed multiply: MULT in1=−3 (0xFFFFFFFD), in2=5 → busy 33 cycles, done once. HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU of same operands → HI=0x00000004, LO=0xFFFFFFF1.
- Signed divide: DIV −7/2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIVU 5/0 → done next cycle, div_zero=1, HI/LO unchanged, result=0x22.
- Back-to-back simple ops: ADD 0xFFFFFFFF+1, SLT 5<3, SLTU 1<0xFFFFFFFF, NOR 0,0 on consecutive cycles → results 0, 0, 1, 0xFFFFFFFF; done high 4 consecutive cycles.
- Start while busy: start=1 with ADD at cycle 5 of a DIVU → ignored. Only one done (the DIVU); result reflects the DIVU quotient.
